rca_load_ou: RTL and testbench
==============================

Name: rca_load_ou

Overview:
- Load operation unit for the RCA fabric; a neighbouring stage of the arithmetic OUs.
- Takes an address operand from upstream OU channels and issues a single load to the LSQ.
- Waits for completion, then holds the loaded word on its output until the downstream OU acknowledges it.
- Produces operands for downstream arithmetic/shift OUs through the standard valid/ack OU handshake.

Parameters:
- FN3, 3'b010, funct3 driven to the LSQ (load width/sign). Constant per instance.
- XLEN, from taiga_config (32), datapath width.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- data_in1  input  XLEN  base address operand
- data_in2  input  XLEN  offset operand (used only with the optional feature)
- data_valid_in1  input  1  data_in1 valid
- data_valid_in2  input  1  data_in2 valid
- data_in_ack1  output  1  data_in1 consumed this cycle
- data_in_ack2  output  1  data_in2 consumed this cycle
- uses_data_in1  output  1  constant 1
- uses_data_in2  output  1  operand-2 usage flag (see Optional Feature)
- data_out  output  XLEN  loaded word
- data_valid_out  output  1  data_out valid
- data_out_ack  input  1  downstream consumed data_out this cycle
- addr  output  XLEN  LSQ request address
- data  output  XLEN  store data; constant 0
- fn3  output  3  constant FN3
- load  output  1  asserted with new_request
- store  output  1  constant 0
- new_request  output  1  LSQ request strobe
- lsq_full  input  1  LSQ cannot accept a request
- load_data  input  XLEN  LSQ load result, already width/sign formatted
- load_complete  input  1  load_data valid, one-cycle pulse

Behaviour:
- All state advances on posedge clk. rst is synchronous: the state machine returns to IDLE and the result register clears to 0.
- Outputs during and after reset: data_valid_out=0, data_out=0, new_request=0, load=0, acks=0, addr=0.
- Constant outputs: data=0, store=0, fn3=FN3, uses_data_in1=1.
- operands_ready = data_valid_in1 (&& data_valid_in2 when the offset feature is enabled).
- fire (combinational) = operands_ready && !lsq_full && (state==IDLE || (state==VALID && data_out_ack)).
- When fire: new_request=1, load=1, addr=effective address, and data_in_ack1=1 in the same cycle (also data_in_ack2 with the offset feature). Acks are never asserted without new_request.
- addr is 0 whenever new_request=0.
- Only one load is ever in flight.

State machine:
- IDLE:
  - fire -> WAIT.
  - load_complete is ignored; this covers stale completions after a reset.
- WAIT:
  - No requests, no acks.
  - On load_complete: result <= load_data, -> VALID.
- VALID:
  - data_valid_out=1, data_out=result.
  - data_out_ack && fire -> WAIT. The new request is issued in the ack cycle, giving back-to-back throughput.
  - data_out_ack && !fire -> IDLE.
  - No ack -> hold; data_out stays stable.
  - load_complete is ignored.
- data_out is combinational from the result register and equals the last loaded word even when data_valid_out=0. After reset it is 0.

Latency and boundaries:
- Minimum latency from fire to data_valid_out is LSQ latency + 1 cycle (result is registered on load_complete).
- lsq_full high: operands wait un-acked; the request issues in the first cycle lsq_full is low.
- Reset during WAIT: the pending load is abandoned; its later load_complete is dropped in IDLE.

Optional Feature:
- Macro: RCA_LOAD_OU_OFFSET_EN.
- Defined:
  - uses_data_in2=1.
  - operands_ready requires both valids.
  - Effective address = data_in1 + data_in2, XLEN-bit, wrapping modulo 2^XLEN.
  - data_in_ack2 mirrors data_in_ack1.
- Undefined:
  - uses_data_in2=0, data_in_ack2=0.
  - data_valid_in2 and data_in2 are ignored.
  - Effective address = data_in1.

Test Plan:
- Single load:
  - Stimulus: data_in1=0x1000 valid, lsq_full=0.
  - Response: same cycle new_request=1, load=1, addr=0x1000, fn3=3'b010, ack1=1. Three cycles later, load_complete with load_data=0xDEADBEEF. Next cycle data_valid_out=1, data_out=0xDEADBEEF. Hold 4 cycles without ack (stable), then ack -> data_valid_out=0 next cycle.
- Backpressure:
  - Stimulus: lsq_full=1 for 5 cycles with the operand valid.
  - Response: no new_request and no ack1 during those cycles. The request fires in the cycle lsq_full drops, addr correct.
- Back-to-back:
  - Stimulus: in VALID, data_out_ack=1 with next operand 0x2000 valid and lsq_full=0.
  - Response: new_request=1 with addr=0x2000 in the ack cycle, state WAIT, data_valid_out=0 the next cycle.
- Reset mid-operation:
  - Stimulus: rst in WAIT, then load_complete with 0x1234 two cycles after reset.
  - Response: data_valid_out stays 0, data_out=0, no new_request.
- Spurious completion:
  - Stimulus: load_complete pulses in IDLE and in VALID.
  - Response: result unchanged, no state change.
- Offset (with RCA_LOAD_OU_OFFSET_EN):
  - Stimulus: data_in1=0xFFFFFFFC, data_in2=0x8, both valid.
  - Response: addr=0x00000004 (wrap), ack1=ack2=1. With only valid1 high: no request.
  - Without the macro: uses_data_in2=0, ack2 always 0.

Source files
------------

// File: rtl/rca_load_ou.sv
// rca_load_ou: load operation unit for the RCA fabric.
//
// Takes a base address (and optionally an offset) from upstream OU channels, issues a single
// load to the LSQ, waits for the completion, then holds the loaded word on data_out until the
// downstream OU acknowledges it. A new load may be issued in the same cycle the previous result
// is acknowledged, so back-to-back loads run without a bubble.
//
// Configuration macro: RCA_LOAD_OU_OFFSET_EN
//   defined   : effective address = data_in1 + data_in2 (wrapping), both operands required,
//               data_in_ack2 mirrors data_in_ack1, uses_data_in2 = 1.
//   undefined : effective address = data_in1, data_in2/data_valid_in2 ignored,
//               data_in_ack2 = 0, uses_data_in2 = 0.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   data_in1/2         base address / offset operands, with data_valid_in1/2
//   data_in_ack1/2     operand consumed this cycle (only together with new_request)
//   uses_data_in1/2    operand usage flags
//   data_out           last loaded word; data_valid_out marks it valid
//   data_out_ack       downstream consumed data_out this cycle
//   addr, data, fn3    LSQ request address, store data (0), funct3 (FN3)
//   load, store        request type strobes (store is always 0)
//   new_request        LSQ request strobe; lsq_full blocks it
//   load_data          LSQ load result, qualified by the one-cycle load_complete pulse

module rca_load_ou #(
  parameter logic [2:0]  FN3  = 3'b010,
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] data_in1,
  input  logic [XLEN-1:0] data_in2,
  input  logic            data_valid_in1,
  input  logic            data_valid_in2,
  output logic            data_in_ack1,
  output logic            data_in_ack2,
  output logic            uses_data_in1,
  output logic            uses_data_in2,
  output logic [XLEN-1:0] data_out,
  output logic            data_valid_out,
  input  logic            data_out_ack,
  output logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] data,
  output logic [2:0]      fn3,
  output logic            load,
  output logic            store,
  output logic            new_request,
  input  logic            lsq_full,
  input  logic [XLEN-1:0] load_data,
  input  logic            load_complete
);

  typedef enum logic [1:0] {StIdle, StWait, StValid} state_e;

  state_e          state_q;
  logic [XLEN-1:0] result_q;

  logic            operands_ready;
  logic [XLEN-1:0] eff_addr;
  logic            slot_free;
  logic            fire;

`ifdef RCA_LOAD_OU_OFFSET_EN
  assign operands_ready = data_valid_in1 && data_valid_in2;
  assign eff_addr       = data_in1 + data_in2;
  assign uses_data_in2  = 1'b1;
  assign data_in_ack2   = fire;
`else
  // Operand 2 is not part of this build; fold it into a sink so it is visibly unused.
  logic unused_in2;
  assign unused_in2     = ^{data_in2, data_valid_in2};
  assign operands_ready = data_valid_in1;
  assign eff_addr       = data_in1;
  assign uses_data_in2  = 1'b0;
  assign data_in_ack2   = 1'b0;
`endif

  // The unit can take a new load when idle, or when the held result leaves this cycle.
  assign slot_free = (state_q == StIdle) || ((state_q == StValid) && data_out_ack);
  // rst gating keeps the request side quiet in the reset cycle itself.
  assign fire      = !rst && operands_ready && !lsq_full && slot_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Completions seen here are stale (e.g. from a load abandoned by reset).
          if (fire) state_q <= StWait;
        end
        StWait: begin
          if (load_complete) begin
            result_q <= load_data;
            state_q  <= StValid;
          end
        end
        StValid: begin
          if (data_out_ack) state_q <= fire ? StWait : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign new_request    = fire;
  assign load           = fire;
  assign addr           = fire ? eff_addr : '0;
  assign data_in_ack1   = fire;

  assign data_valid_out = !rst && (state_q == StValid);
  assign data_out       = rst ? '0 : result_q;

  assign data           = '0;
  assign store          = 1'b0;
  assign fn3            = FN3;
  assign uses_data_in1  = 1'b1;

endmodule

// File: tb/tb_rca_load_ou.sv
module tb_rca_load_ou;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in1, data_in2;
  logic        data_valid_in1, data_valid_in2;
  logic        data_in_ack1, data_in_ack2;
  logic        uses_data_in1, uses_data_in2;
  logic [31:0] data_out;
  logic        data_valid_out;
  logic        data_out_ack;
  logic [31:0] addr, data;
  logic [2:0]  fn3;
  logic        load, store, new_request;
  logic        lsq_full;
  logic [31:0] load_data;
  logic        load_complete;

  rca_load_ou #(.FN3(3'b010), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in1       (data_in1),
    .data_in2       (data_in2),
    .data_valid_in1 (data_valid_in1),
    .data_valid_in2 (data_valid_in2),
    .data_in_ack1   (data_in_ack1),
    .data_in_ack2   (data_in_ack2),
    .uses_data_in1  (uses_data_in1),
    .uses_data_in2  (uses_data_in2),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .data_out_ack   (data_out_ack),
    .addr           (addr),
    .data           (data),
    .fn3            (fn3),
    .load           (load),
    .store          (store),
    .new_request    (new_request),
    .lsq_full       (lsq_full),
    .load_data      (load_data),
    .load_complete  (load_complete)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Inputs change 1 time unit after the active edge; combinational checks follow 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (data_valid_out && data_out_ack) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard: unexpected output %h, expected none", data_out);
      end else begin
        chk("scoreboard data_out", data_out, exp_q.pop_front());
      end
    end
  end

  // Drive load_complete for one cycle and record the word the monitor should later see.
  task automatic complete(input logic [31:0] word, input bit expect_out);
    load_complete = 1'b1;
    load_data     = word;
    if (expect_out) exp_q.push_back(word);
    cyc();
    load_complete = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    data_in1 = '0; data_in2 = '0; data_valid_in1 = 0; data_valid_in2 = 0;
    data_out_ack = 0; lsq_full = 0; load_data = '0; load_complete = 0;
    cyc(); cyc();
    // Request side stays quiet during reset even with an operand offered.
    data_valid_in1 = 1; data_in1 = 32'h0000_0AAA;
    #1;
    chk("reset new_request", new_request, 0);
    chk("reset ack1", data_in_ack1, 0);
    chk("reset addr", addr, 0);
    data_valid_in1 = 0;
    cyc();
    rst = 1'b0;
    #1;
    chk("idle valid_out", data_valid_out, 0);
    chk("idle data_out", data_out, 0);
    chk("idle new_request", new_request, 0);
    chk("idle addr", addr, 0);
    chk("const data", data, 0);
    chk("const store", store, 0);
    chk("const fn3", fn3, 3'b010);
    chk("const uses1", uses_data_in1, 1);

    // Single load.
    cyc();
    data_in1 = 32'h0000_1000; data_valid_in1 = 1;
    #1;
    chk("single new_request", new_request, 1);
    chk("single load", load, 1);
    chk("single addr", addr, 32'h0000_1000);
    chk("single ack1", data_in_ack1, 1);
    cyc();
    data_valid_in1 = 0;
    #1;
    chk("wait new_request", new_request, 0);
    chk("wait ack1", data_in_ack1, 0);
    cyc(); cyc();
    complete(32'hDEAD_BEEF, 1);
    chk("single valid_out", data_valid_out, 1);
    chk("single data_out", data_out, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) load_complete = 1; // spurious completion in VALID
      load_data = 32'h5555_5555;
      cyc();
      load_complete = 0;
      #1;
      chk("hold valid_out", data_valid_out, 1);
      chk("hold data_out", data_out, 32'hDEAD_BEEF);
    end
    data_out_ack = 1;
    #1;
    chk("ack no-operand new_request", new_request, 0);
    cyc();
    data_out_ack = 0;
    #1;
    chk("after ack valid_out", data_valid_out, 0);
    chk("after ack data_out", data_out, 32'hDEAD_BEEF);

    // Spurious completion in IDLE.
    complete(32'h7777_7777, 0);
    chk("idle spurious valid_out", data_valid_out, 0);
    chk("idle spurious data_out", data_out, 32'hDEAD_BEEF);

    // Backpressure.
    lsq_full = 1; data_in1 = 32'h0000_3000; data_valid_in1 = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("full new_request", new_request, 0);
      chk("full ack1", data_in_ack1, 0);
      cyc();
    end
    lsq_full = 0;
    #1;
    chk("unfull new_request", new_request, 1);
    chk("unfull addr", addr, 32'h0000_3000);
    chk("unfull ack1", data_in_ack1, 1);
    cyc();
    data_valid_in1 = 0;
    complete(32'hCAFE_F00D, 1);
    chk("bp valid_out", data_valid_out, 1);

    // Back-to-back: next request issues in the ack cycle.
    data_out_ack = 1; data_in1 = 32'h0000_2000; data_valid_in1 = 1;
    #1;
    chk("b2b new_request", new_request, 1);
    chk("b2b addr", addr, 32'h0000_2000);
    chk("b2b ack1", data_in_ack1, 1);
    cyc();
    data_out_ack = 0; data_valid_in1 = 0;
    #1;
    chk("b2b valid_out", data_valid_out, 0);
    chk("b2b wait new_request", new_request, 0);
    complete(32'h0BAD_CAFE, 1);
    chk("b2b2 data_out", data_out, 32'h0BAD_CAFE);
    data_out_ack = 1;
    cyc();
    data_out_ack = 0;

    // Reset during WAIT; the late completion must be dropped.
    data_in1 = 32'h0000_4000; data_valid_in1 = 1;
    cyc();
    data_valid_in1 = 0;
    rst = 1;
    cyc();
    rst = 0;
    cyc();
    complete(32'h0000_1234, 0);
    chk("rst-wait valid_out", data_valid_out, 0);
    chk("rst-wait data_out", data_out, 0);
    chk("rst-wait new_request", new_request, 0);
    cyc();
    chk("rst-wait later valid_out", data_valid_out, 0);

`ifdef RCA_LOAD_OU_OFFSET_EN
    chk("uses2", uses_data_in2, 1);
    data_in1 = 32'hFFFF_FFFC; data_in2 = 32'h0000_0008; data_valid_in1 = 1; data_valid_in2 = 0;
    #1;
    chk("offset only-valid1 new_request", new_request, 0);
    chk("offset only-valid1 ack1", data_in_ack1, 0);
    data_valid_in2 = 1;
    #1;
    chk("offset new_request", new_request, 1);
    chk("offset addr wrap", addr, 32'h0000_0004);
    chk("offset ack1", data_in_ack1, 1);
    chk("offset ack2", data_in_ack2, 1);
`else
    chk("uses2", uses_data_in2, 0);
    data_in1 = 32'hFFFF_FFFC; data_in2 = 32'h0000_0008; data_valid_in1 = 1; data_valid_in2 = 1;
    #1;
    chk("no-offset new_request", new_request, 1);
    chk("no-offset addr", addr, 32'hFFFF_FFFC);
    chk("no-offset ack2", data_in_ack2, 0);
`endif
    cyc();
    data_valid_in1 = 0; data_valid_in2 = 0;
    complete(32'h1357_9BDF, 1);
    chk("final data_out", data_out, 32'h1357_9BDF);
    data_out_ack = 1;
    cyc();
    data_out_ack = 0;
    cyc();
    chk("scoreboard drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
